// File: rtl/ddr3_wr_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_wr_control_pkg
// Description : Shared types and constants for the DDR3 write controller:
//               FSM state encoding, write command code, data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_wr_control_pkg;

    localparam int DIN_W  = 128;   // FIFO word width
    localparam int DOUT_W = 256;   // application write-data width

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PACK_HI = 2'd1,
        ST_ISSUE   = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/ddr3_wr_control.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_wr_control
// Description : Packs two 128-bit FWFT FIFO words into one 256-bit DDR3
//               application write and issues it with independent command and
//               write-data handshakes; address and write counters inline.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_wr_control
    import ddr3_wr_control_pkg::*;
#(
    parameter int ADDR_W   = 27,
    parameter int ADDR_INC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DIN_W-1:0]  fifo_dout,
    output logic              fifo_rd_en,
    input  logic              init_calib_complete,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic [DOUT_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              addr_reset,
    output logic              ddr3_wr_busy,
    output logic [23:0]       wr_cnt
);

    wr_state_t state;
    wr_state_t state_next;

    logic cmd_done;        // command accepted earlier in this ISSUE
    logic data_done;       // write data accepted earlier in this ISSUE
    logic addr_rst_pend;   // addr_reset seen during ISSUE, applied on completion
    logic cmd_acc;
    logic data_acc;
    logic write_done;
    logic rd_ok;

    assign app_cmd    = APP_CMD_WRITE;
    // Reset gates the pop so the FIFO is never drained while held in reset.
    assign rd_ok      = !fifo_empty && init_calib_complete && !reset;
    assign cmd_acc    = (state == ST_ISSUE) && app_en && app_rdy;
    assign data_acc   = (state == ST_ISSUE) && app_wdf_wren && app_wdf_rdy;
    assign write_done = (state == ST_ISSUE) && (cmd_done || cmd_acc) && (data_done || data_acc);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and FIFO pop decode
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        case (state)
            ST_IDLE: begin
                fifo_rd_en = rd_ok;
                if (rd_ok) state_next = ST_PACK_HI;
            end
            ST_PACK_HI: begin
                fifo_rd_en = rd_ok;
                if (rd_ok) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (write_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data packing and the two independent handshakes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            app_wdf_data <= '0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
        end else begin
            if (state == ST_IDLE && fifo_rd_en)
                app_wdf_data[DIN_W-1:0] <= fifo_dout;
            if (state == ST_PACK_HI && fifo_rd_en) begin
                app_wdf_data[DOUT_W-1:DIN_W] <= fifo_dout;
                app_en       <= 1'b1;
                app_wdf_wren <= 1'b1;
                app_wdf_end  <= 1'b1;
            end
            if (cmd_acc) begin
                app_en   <= 1'b0;
                cmd_done <= 1'b1;
            end
            if (data_acc) begin
                app_wdf_wren <= 1'b0;
                app_wdf_end  <= 1'b0;
                data_done    <= 1'b1;
            end
            // Completion overrides the flag sets above
            if (write_done) begin
                cmd_done  <= 1'b0;
                data_done <= 1'b0;
            end
        end
    end

    // Write address and completed-write counter; an addr_reset during ISSUE
    // is deferred so the outstanding write keeps its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            app_addr      <= '0;
            wr_cnt        <= '0;
            addr_rst_pend <= 1'b0;
        end else if (write_done) begin
            app_addr      <= (addr_rst_pend || addr_reset) ? '0
                             : app_addr + ADDR_W'(ADDR_INC);
            wr_cnt        <= wr_cnt + 24'd1;
            addr_rst_pend <= 1'b0;
        end else if (addr_reset) begin
            if (state == ST_ISSUE) addr_rst_pend <= 1'b1;
            else                   app_addr      <= '0;
        end
    end

    // Registered busy indication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ddr3_wr_busy <= 1'b0;
        else       ddr3_wr_busy <= (state != ST_IDLE) || !fifo_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_wr_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_wr_control
// Description : Self-checking bench for ddr3_wr_control. A queue models the
//               FWFT FIFO; expected writes go into a scoreboard queue when
//               their words are queued and are compared on acceptance.
//               The address space is shrunk to 8 bits so wrap is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_wr_control;

    localparam int ADDR_W   = 8;
    localparam int ADDR_INC = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [255:0]      data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fifo_empty = 1'b1;
    logic [127:0]      fifo_dout = '0;
    logic              fifo_rd_en;
    logic              init_calib_complete = 1'b0;
    logic              app_rdy = 1'b0;
    logic              app_wdf_rdy = 1'b0;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [255:0]      app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              addr_reset = 1'b0;
    logic              ddr3_wr_busy;
    logic [23:0]       wr_cnt;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    wr_t               exp_q[$];
    logic [127:0]      fifo_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;

    ddr3_wr_control #(.ADDR_W(ADDR_W), .ADDR_INC(ADDR_INC)) dut (
        .clk                (clk),
        .reset              (reset),
        .fifo_empty         (fifo_empty),
        .fifo_dout          (fifo_dout),
        .fifo_rd_en         (fifo_rd_en),
        .init_calib_complete(init_calib_complete),
        .app_rdy            (app_rdy),
        .app_wdf_rdy        (app_wdf_rdy),
        .app_en             (app_en),
        .app_cmd            (app_cmd),
        .app_addr           (app_addr),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .addr_reset         (addr_reset),
        .ddr3_wr_busy       (ddr3_wr_busy),
        .wr_cnt             (wr_cnt)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: pop on an edge with fifo_rd_en, then refresh the head
    always @(posedge clk) begin
        logic pop_now;
        pop_now = fifo_rd_en;
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    end

    // Scoreboard: a write is complete once both handshakes have been seen
    logic              mon_cmd  = 1'b0;
    logic              mon_data = 1'b0;
    logic [ADDR_W-1:0] mon_addr;
    logic [255:0]      mon_wdata;
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            mon_cmd  = 1'b0;
            mon_data = 1'b0;
        end else begin
            if (app_en && app_rdy) begin
                mon_cmd  = 1'b1;
                mon_addr = app_addr;
                checks++;
                if (app_cmd !== 3'b000) begin
                    errors++;
                    $display("FAIL app_cmd: got %b want 000", app_cmd);
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                mon_data  = 1'b1;
                mon_wdata = app_wdf_data;
                checks++;
                if (app_wdf_end !== 1'b1) begin
                    errors++;
                    $display("FAIL wdf_end: got %b want 1", app_wdf_end);
                end
            end
            if (mon_cmd && mon_data) begin
                mon_cmd  = 1'b0;
                mon_data = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %h, none expected", mon_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (mon_addr !== e.addr || mon_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write: got addr %h data %h want addr %h data %h",
                                 mon_addr, mon_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic queue_write();
        logic [127:0] a, b;
        a = rnd128();
        b = rnd128();
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        exp_q.push_back('{addr: exp_addr, data: {b, a}});
        exp_addr = exp_addr + ADDR_W'(ADDR_INC);
    endtask

    task automatic wait_cnt(input logic [23:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_cnt == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (app_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        fifo_q.push_back(rnd128());
        init_calib_complete = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000", {app_en, app_wdf_wren, app_wdf_end});
        end
        checks++;
        if (app_addr !== '0 || wr_cnt !== '0 || app_wdf_data !== '0) begin
            errors++;
            $display("FAIL reset_regs: got addr %h cnt %h data %h want 0", app_addr, wr_cnt, app_wdf_data);
        end
        checks++;
        if (fifo_rd_en !== 1'b0 || ddr3_wr_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_busy: got rd_en %b busy %b want 0 0", fifo_rd_en, ddr3_wr_busy);
        end
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        @(posedge clk); #2;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        queue_write();
        wait_cnt(24'd1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got cnt %0d want 1", wr_cnt); end
        checks++;
        if (app_addr !== 8'h08 || app_en !== 1'b0) begin
            errors++;
            $display("FAIL single_after: got addr %h en %b want 08 0", app_addr, app_en);
        end
    endtask

    task automatic test_cmd_delay();
        bit ok;
        int p0, en_cycles;
        @(posedge clk); #2;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b1;
        p0 = pops;
        queue_write();
        wait_en(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL delay_en_timeout: got en %b want 1", app_en); end
        en_cycles = 1;
        checks++;
        if (app_wdf_wren !== 1'b1) begin errors++; $display("FAIL delay_wren_first: got %b want 1", app_wdf_wren); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (i == 3) app_rdy = 1'b1;
            @(negedge clk);
            if (app_en) en_cycles++;
            if (i == 0) begin
                checks++;
                if (app_wdf_wren !== 1'b0) begin errors++; $display("FAIL delay_wren_drop: got %b want 0", app_wdf_wren); end
            end
        end
        @(negedge clk);
        checks++;
        if (en_cycles != 5 || app_en !== 1'b0) begin
            errors++;
            $display("FAIL delay_en_cycles: got %0d en %b want 5 0", en_cycles, app_en);
        end
        checks++;
        if (wr_cnt !== 24'd2 || pops - p0 != 2) begin
            errors++;
            $display("FAIL delay_count: got cnt %0d pops %0d want 2 2", wr_cnt, pops - p0);
        end
    endtask

    task automatic test_calib();
        bit ok;
        int p0, rd_seen;
        @(posedge clk); #2;
        init_calib_complete = 1'b0;
        p0 = pops;
        rd_seen = 0;
        queue_write();
        repeat (6) begin
            @(negedge clk);
            if (fifo_rd_en) rd_seen++;
        end
        checks++;
        if (rd_seen != 0 || pops != p0 || ddr3_wr_busy !== 1'b1) begin
            errors++;
            $display("FAIL calib_hold: got rd %0d pops %0d busy %b want 0 0 1", rd_seen, pops - p0, ddr3_wr_busy);
        end
        init_calib_complete = 1'b1;
        wait_cnt(24'd3, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL calib_timeout: got cnt %0d want 3", wr_cnt); end
    endtask

    task automatic test_fifo_gap();
        bit ok;
        int en_seen;
        logic [127:0] a, b;
        a = rnd128();
        b = rnd128();
        @(posedge clk); #2;
        exp_q.push_back('{addr: exp_addr, data: {b, a}});
        exp_addr = exp_addr + ADDR_W'(ADDR_INC);
        fifo_q.push_back(a);
        repeat (3) @(negedge clk);
        en_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (app_en || fifo_rd_en) en_seen++;
        end
        checks++;
        if (en_seen != 0 || app_wdf_data[127:0] !== a || ddr3_wr_busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_hold: got act %0d lo %h busy %b want 0 %h 1", en_seen, app_wdf_data[127:0], ddr3_wr_busy, a);
        end
        fifo_q.push_back(b);
        wait_cnt(24'd4, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gap_timeout: got cnt %0d want 4", wr_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c;
        @(posedge clk); #2;
        repeat (4) queue_write();
        wait_cnt(24'd5, 50, ok);
        c = 0;
        while (wr_cnt != 24'd8 && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!ok || c != 9) begin
            errors++;
            $display("FAIL cadence: got %0d cycles for 3 writes want 9", c);
        end
    endtask

    task automatic test_addr_reset();
        bit ok;
        @(posedge clk); #2;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        queue_write();
        wait_en(ok);
        checks++;
        if (!ok || app_addr !== 8'h40) begin
            errors++;
            $display("FAIL ar_issue_addr: got %h want 40", app_addr);
        end
        @(posedge clk); #2;
        addr_reset = 1'b1;
        @(posedge clk); #2;
        addr_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (app_addr !== 8'h40 || app_en !== 1'b1) begin
            errors++;
            $display("FAIL ar_stable: got addr %h en %b want 40 1", app_addr, app_en);
        end
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        wait_cnt(24'd9, 50, ok);
        checks++;
        if (!ok || app_addr !== 8'h00) begin
            errors++;
            $display("FAIL ar_after: got cnt %0d addr %h want 9 00", wr_cnt, app_addr);
        end
        exp_addr = '0;
        queue_write();
        wait_cnt(24'd10, 50, ok);
        checks++;
        if (!ok || app_addr !== 8'h08) begin
            errors++;
            $display("FAIL ar_next: got cnt %0d addr %h want 10 08", wr_cnt, app_addr);
        end
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        @(posedge clk); #2;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        fifo_q.push_back(rnd128());
        fifo_q.push_back(rnd128());
        wait_en(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_en_timeout: got en %b want 1", app_en); end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_ctrl: got %b want 0000", {app_en, app_wdf_wren, app_wdf_end, fifo_rd_en});
        end
        checks++;
        if (app_addr !== '0 || app_wdf_data !== '0 || wr_cnt !== '0) begin
            errors++;
            $display("FAIL mid_regs: got addr %h cnt %h data %h want 0", app_addr, wr_cnt, app_wdf_data);
        end
        @(negedge clk);
        checks++;
        if (ddr3_wr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", ddr3_wr_busy); end
        @(posedge clk); #2;
        reset = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        exp_addr = '0;
        queue_write();
        wait_cnt(24'd1, 50, ok);
        checks++;
        if (!ok || app_addr !== 8'h08) begin
            errors++;
            $display("FAIL mid_next: got cnt %0d addr %h want 1 08", wr_cnt, app_addr);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        @(posedge clk); #2;
        repeat (30) queue_write();
        wait_cnt(24'd31, 400, ok);
        checks++;
        if (!ok || app_addr !== 8'hF8) begin
            errors++;
            $display("FAIL wrap_preset: got cnt %0d addr %h want 31 f8", wr_cnt, app_addr);
        end
        queue_write();
        queue_write();
        wait_cnt(24'd33, 50, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || wr_cnt !== 24'd33 || app_addr !== 8'h08) begin
            errors++;
            $display("FAIL wrap_after: got cnt %0d addr %h want 33 08", wr_cnt, app_addr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cmd_delay();
        test_calib();
        test_fifo_gap();
        test_back_to_back();
        test_addr_reset();
        test_reset_mid_issue();
        test_wrap();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got exp %0d fifo %0d left want 0 0", exp_q.size(), fifo_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_wr_control.md
DDR3_WR_CONTROL -- requirements
Module: ddr3_wr_control

Interface
REQ-001 Parameter: ADDR_W, 27, DDR3 application address width.
REQ-002 Parameter: ADDR_INC, 8, address step per 256-bit application write.
REQ-003 Port: clk  in  1  single clock for all logic.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: fifo_empty  in  1  ADC storage FIFO empty; FIFO is first-word-fall-through.
REQ-006 Port: fifo_dout  in  128  FIFO head word, valid while fifo_empty=0.
REQ-007 Port: fifo_rd_en  out  1  pops head word in the cycle asserted.
REQ-008 Port: init_calib_complete  in  1  DDR3 controller calibrated.
REQ-009 Port: app_rdy / app_wdf_rdy  in  1 each  controller command / write-data accept.
REQ-010 Port: app_en  out  1  command valid.
REQ-011 Port: app_cmd  out  3  command; constant 3'b000 (write).
REQ-012 Port: app_addr  out  ADDR_W  write address.
REQ-013 Port: app_wdf_data  out  256  packed write data.
REQ-014 Port: app_wdf_wren / app_wdf_end  out  1 each  write-data valid / last beat.
REQ-015 Port: addr_reset  in  1  synchronous request to return the write address to 0.
REQ-016 Port: ddr3_wr_busy  out  1  writer not idle or FIFO not empty.
REQ-017 Port: wr_cnt  out  24  completed application writes since reset.

Function
REQ-018 States: IDLE, PACK_HI, ISSUE; no others.
REQ-019 fifo_rd_en SHALL be combinational: 1 when (IDLE or PACK_HI) and fifo_empty=0 and init_calib_complete=1; otherwise 0.
REQ-020 IDLE: on a pop, capture fifo_dout into app_wdf_data[127:0]; go to PACK_HI; otherwise stay.
REQ-021 PACK_HI: on a pop, capture fifo_dout into app_wdf_data[255:128]; next cycle app_en, app_wdf_wren and app_wdf_end = 1; go to ISSUE; otherwise stay, holding the low half.
REQ-022 ISSUE: app_en held until sampled with app_rdy=1, then cleared next cycle.
REQ-023 ISSUE: app_wdf_wren and app_wdf_end held until sampled with app_wdf_rdy=1, then cleared next cycle.
REQ-024 Command and data acceptance are independent and may occur in either order or in the same cycle; track with two done flags.
REQ-025 When both accepted: app_addr += ADDR_INC (wraps modulo 2^ADDR_W); wr_cnt += 1 (wraps at 2^24); go to IDLE.
REQ-026 app_addr, app_wdf_data and app_cmd SHALL be stable while app_en or app_wdf_wren is 1.
REQ-027 Minimum cadence: 3 cycles per write (IDLE pop, PACK_HI pop, ISSUE accept).
REQ-028 addr_reset in IDLE or PACK_HI: app_addr <= 0 next cycle.
REQ-029 addr_reset in ISSUE: the pending write completes at its current address; the next write uses address 0.
REQ-030 init_calib_complete low: no pops; an in-progress ISSUE still completes.
REQ-031 ddr3_wr_busy SHALL be registered: 1 when state != IDLE or fifo_empty=0, sampled each clk.

Reset
REQ-032 Reset SHALL asynchronously force: state IDLE, fifo_rd_en 0, app_en 0, app_wdf_wren 0, app_wdf_end 0, app_addr 0, app_wdf_data 0, wr_cnt 0, ddr3_wr_busy 0, done flags 0.
REQ-033 Reset mid-ISSUE SHALL abandon the write; the half-packed word is discarded.
REQ-034 No output SHALL change on a clk edge while reset=1.

Structure
REQ-035 A shared package SHALL hold the state encoding, APP_CMD_WRITE=3'b000 and the 128/256 data widths.
REQ-036 Single module with no sub-modules; address and wr_cnt counters inline.

Verification
REQ-037 Two FIFO words A, B; app_rdy = app_wdf_rdy = 1 -> one write: data {B,A}, addr 0; wr_cnt=1; addr becomes 8.
REQ-038 app_rdy delayed 5 cycles, app_wdf_rdy immediate -> wren drops after 1 cycle; app_en held 5 cycles; a single write completes; no extra pops.
REQ-039 One word, then a 10-cycle FIFO gap, then a second word -> FSM waits in PACK_HI; low half unchanged; write issued after the second word.
REQ-040 addr_reset pulsed during ISSUE at addr 0x40 -> write goes to 0x40; next write goes to 0.
REQ-041 app_addr preset near 2^27-8, two writes -> second write at 0; wr_cnt=2.
REQ-042 reset asserted mid-ISSUE -> all outputs zero immediately; busy 0; next write goes to addr 0.
